// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port main-memory arbiter between an I-cache refill port
// and a D-cache refill/writeback port. One memory transaction runs at a time.
// D-side wins simultaneous requests until it has been granted STARVE_LIMIT
// times in a row while the I-side was waiting; then the I-side gets a turn.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   i_req, i_addr         I-side refill request (held until i_done)
//   i_rdata, i_done       I-side refill line and one-cycle completion pulse
//   d_req, d_we, d_addr,  D-side request; d_we=1 writeback, 0 refill
//   d_wdata               D-side writeback line
//   d_rdata, d_done       D-side refill line and one-cycle completion pulse
//   mem_req, mem_we,      main-memory request, held for the whole grant
//   mem_addr, mem_wdata   (address is line aligned)
//   mem_rdata, mem_ready  main-memory read line and one-cycle completion
//   busy                  arbiter not idle
//   owner                 current grant, 0 = I, 1 = D (valid with mem_req)
//
// state   | meaning
// IDLE    | no transaction; requests sampled here only
// GRANT_I | I-side refill in flight, waiting for mem_ready
// GRANT_D | D-side refill or writeback in flight, waiting for mem_ready
// DONE    | one-cycle turnaround while the done pulse is visible
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [31:0]  i_addr,
  output logic [127:0] i_rdata,
  output logic         i_done,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_done,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         busy,
  output logic         owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] STREAK_LIMIT = 2'(STARVE_LIMIT);
  localparam logic [31:0] LINE_MASK = ~32'h0000_000F;

  state_t       state_q, state_d;
  logic [1:0]   d_streak_q, d_streak_d;
  logic         mem_req_q, mem_req_d;
  logic         mem_we_q, mem_we_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [127:0] i_rdata_q, i_rdata_d;
  logic [127:0] d_rdata_q, d_rdata_d;
  logic         i_done_q, i_done_d;
  logic         d_done_q, d_done_d;
  logic         busy_q, busy_d;
  logic         owner_q, owner_d;

  always_comb begin
    state_d     = state_q;
    d_streak_d  = d_streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    owner_d     = owner_q;

    case (state_q)
      IDLE: begin
        // I-side wins only when alone or when the D-side streak has hit the limit.
        if (i_req && (!d_req || d_streak_q == STREAK_LIMIT)) begin
          state_d     = GRANT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr & LINE_MASK;
          mem_wdata_d = '0;
          owner_d     = 1'b0;
          d_streak_d  = 2'd0;
        end else if (d_req) begin
          state_d     = GRANT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr & LINE_MASK;
          mem_wdata_d = d_wdata;
          owner_d     = 1'b1;
          if (i_req) begin
            d_streak_d = (d_streak_q == 2'd3) ? 2'd3 : d_streak_q + 2'd1;
          end else begin
            d_streak_d = 2'd0;
          end
        end else begin
          d_streak_d = 2'd0;
        end
      end

      GRANT_I: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          i_rdata_d = mem_rdata;
          i_done_d  = 1'b1;
        end
      end

      GRANT_D: begin
        if (mem_ready) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_done_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      d_streak_q  <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_streak_q  <= d_streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req;
  logic [31:0]  i_addr;
  logic [127:0] i_rdata;
  logic         i_done;
  logic         d_req;
  logic         d_we;
  logic [31:0]  d_addr;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_done;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         owner;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .owner     (owner)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_mem_req(input int max_cycles);
    int n = 0;
    while (mem_req !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("mem_req_seen", mem_req, 1'b1);
  endtask

  // Waits for the grant, checks the latched request, holds it lat cycles,
  // then answers with mem_ready and checks the completion cycle.
  task automatic serve(input int lat, input logic [127:0] rdata, input logic exp_owner,
                       input logic exp_we, input logic [31:0] exp_addr,
                       input logic [127:0] exp_wdata);
    logic [127:0] old_i;
    logic [127:0] old_d;
    wait_mem_req(20);
    check_eq("owner", owner, exp_owner);
    check_eq("mem_we", mem_we, exp_we);
    check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("busy_grant", busy, 1'b1);
    if (exp_owner && exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
    old_i = i_rdata;
    old_d = d_rdata;
    for (int k = 0; k < lat; k++) begin
      tick();
      check_eq("mem_req_hold", mem_req, 1'b1);
      check_eq("mem_addr_hold", mem_addr, exp_addr);
      check_eq("early_done", {i_done, d_done}, 2'b00);
    end
    mem_rdata = rdata;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq("mem_req_drop", mem_req, 1'b0);
    check_eq("i_done", i_done, !exp_owner);
    check_eq("d_done", d_done, exp_owner);
    check_eq("i_rdata", i_rdata, exp_owner ? old_i : rdata);
    check_eq("d_rdata", d_rdata, (exp_owner && !exp_we) ? rdata : old_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [1:0] exp_streak;
    logic [127:0] rd;
    logic exp_own [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    check_eq("rst_outputs", {mem_req, mem_we, i_done, d_done, busy, owner}, 6'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_rdata", {i_rdata, d_rdata}, 256'h0);
    reset = 1'b1;

    // I-side refill, 5 cycles request to done
    i_req = 1'b1; i_addr = 32'h0000_0044;
    c0 = cyc;
    serve(3, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b0, 32'h0000_0040, '0);
    check_eq("i_latency", cyc - c0, 5);
    i_req = 1'b0;
    tick();
    check_eq("after_i_done", {i_done, d_done, busy}, 3'b000);

    // D-side writeback leaves d_rdata alone
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1234_567C;
    d_wdata = {4{32'hDEADBEEF}};
    serve(1, 128'hAAAA, 1'b1, 1'b1, 32'h1234_5670, {4{32'hDEADBEEF}});
    d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("after_wb", {i_done, d_done, busy}, 3'b000);

    // Both sides hold requests: D, D, I, D, D, I
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0208;
    i_req = 1'b1; d_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      rd = 128'h5000 + 128'(g);
      exp_streak = (g % 3 == 0) ? 2'd1 : (g % 3 == 1) ? 2'd2 : 2'd0;
      serve(1, rd, exp_own[g], 1'b0, exp_own[g] ? 32'h0000_0200 : 32'h0000_0100, '0);
      check_eq("d_streak", dut.d_streak_q, exp_streak);
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    check_eq("starve_idle", busy, 1'b0);

    // Reset in the second GRANT_D cycle abandons the transaction
    d_req = 1'b1; d_addr = 32'h0000_0300;
    tick();
    check_eq("g1_mem_req", mem_req, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_mid_outputs", {mem_req, d_done, busy, owner}, 4'b0000);
    reset = 1'b1; d_req = 1'b0;
    tick(); tick();
    check_eq("rst_mid_no_done", {i_done, d_done, busy}, 3'b000);
    i_req = 1'b1; i_addr = 32'h0000_0404;
    serve(2, 128'h7777, 1'b0, 1'b0, 32'h0000_0400, '0);
    i_req = 1'b0;
    tick();

    // Stray mem_ready in IDLE, then d_addr moved mid-grant
    mem_ready = 1'b1; mem_rdata = 128'hBAD;
    tick();
    mem_ready = 1'b0;
    tick();
    check_eq("stray_done", {i_done, d_done, busy}, 3'b000);
    check_eq("stray_i_rdata", i_rdata, 128'h7777);
    check_eq("stray_d_rdata", d_rdata, 128'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0510;
    tick();
    check_eq("latched_addr", mem_addr, 32'h0000_0510);
    d_addr = 32'h0000_0FF0; d_req = 1'b0;
    serve(2, 128'h9999, 1'b1, 1'b0, 32'h0000_0510, '0);
    tick();
    check_eq("final_idle", {i_done, d_done, busy}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2, meaning the maximum number of consecutive D-side grants allowed while an I-side request waits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port i_req  input  1  instruction-side line-refill request, held until i_done.
REQ-005 SHALL have port i_addr  input  32  instruction-side byte address.
REQ-006 SHALL have port i_rdata  output  128  instruction-side refill line.
REQ-007 SHALL have port i_done  output  1  one-cycle completion pulse to the I-side.
REQ-008 SHALL have port d_req  input  1  data-side request (refill or writeback), held until d_done.
REQ-009 SHALL have port d_we  input  1  data-side request is a writeback when 1, a refill when 0.
REQ-010 SHALL have port d_addr  input  32  data-side byte address.
REQ-011 SHALL have port d_wdata  input  128  data-side writeback line.
REQ-012 SHALL have port d_rdata  output  128  data-side refill line.
REQ-013 SHALL have port d_done  output  1  one-cycle completion pulse to the D-side.
REQ-014 SHALL have port mem_req  output  1  main-memory request.
REQ-015 SHALL have port mem_we  output  1  main-memory write enable.
REQ-016 SHALL have port mem_addr  output  32  line-aligned main-memory address.
REQ-017 SHALL have port mem_wdata  output  128  main-memory write line.
REQ-018 SHALL have port mem_rdata  input  128  main-memory read line.
REQ-019 SHALL have port mem_ready  input  1  main-memory completion, 1 cycle.
REQ-020 SHALL have port busy  output  1  arbiter is not IDLE.
REQ-021 SHALL have port owner  output  1  current grant: 0 = I, 1 = D; valid while mem_req=1.

Function
REQ-022 SHALL implement the FSM states IDLE, GRANT_I, GRANT_D and DONE, with every output registered.
REQ-023 In IDLE, with only i_req=1, SHALL go to GRANT_I; with only d_req=1, SHALL go to GRANT_D; with neither, SHALL stay in IDLE.
REQ-024 In IDLE with both requests high, SHALL go to GRANT_D, unless d_streak==STARVE_LIMIT, in which case it SHALL go to GRANT_I.
REQ-025 d_streak (2-bit saturating counter) SHALL increment on each GRANT_D entry taken while i_req=1.
REQ-026 d_streak SHALL clear on each GRANT_I entry, and on any IDLE cycle with i_req=0.
REQ-027 On GRANT entry, SHALL latch the request's address, write data and we into mem_* in the same edge, so mem_req=1 on the first GRANT cycle (1-cycle request-to-mem_req latency).
REQ-028 I-side grants SHALL always drive mem_we=0.
REQ-029 mem_addr SHALL be the latched address with bits [3:0] forced to 0.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable for the whole GRANT state.
REQ-031 In GRANT_x with mem_ready=1, the next edge SHALL:
- drop mem_req;
- capture mem_rdata into i_rdata or d_rdata (reads only; unchanged on writeback);
- pulse the matching done for exactly one cycle;
- enter DONE.
REQ-032 DONE SHALL last exactly one cycle, then go to IDLE; requests are not sampled in DONE.
REQ-033 Requesters deassert req on the edge after done, so a minimum of 3 cycles separates back-to-back transactions.
REQ-034 mem_ready while not in GRANT SHALL be ignored.
REQ-035 Request input changes after grant SHALL be ignored until DONE; a dropped req does not abort the transaction.
REQ-036 i_rdata and d_rdata SHALL hold their value until the next read completion on that side.
REQ-037 No done pulse SHALL be issued for a writeback other than d_done, and never both dones in the same cycle.

Reset
REQ-038 When reset=0 at a clock edge, the next state SHALL be:
- state=IDLE;
- mem_req, mem_we, i_done, d_done, busy and owner = 0;
- mem_addr, mem_wdata, i_rdata, d_rdata and d_streak = 0.
REQ-039 Reset mid-transaction SHALL abandon the transaction: mem_req low on the next cycle and no done pulse; the memory discards the abandoned access.
REQ-040 The first request is accepted in the first IDLE cycle after reset returns to 1.

Verification
REQ-041 I read: i_req=1, i_addr=0x0000_0044, mem_ready high 3 cycles after mem_req -> mem_addr=0x0000_0040, mem_we=0, i_rdata=mem_rdata, i_done one pulse; i_req to i_done is 5 cycles.
REQ-042 D writeback: d_req=1, d_we=1, d_wdata=0xDEADBEEF_x4 -> mem_we=1, mem_wdata matches, d_done pulses, d_rdata unchanged.
REQ-043 Simultaneous i_req and d_req held continuously, STARVE_LIMIT=2 -> grant order D, D, I, D, D, I; d_streak clears after each I grant.
REQ-044 Reset asserted in the 2nd cycle of GRANT_D -> mem_req=0 the next cycle, no d_done, state IDLE; a new i_req after release is served normally.
REQ-045 Stray mem_ready=1 in IDLE, plus d_addr changed mid-GRANT -> no done pulse and no capture from the stray mem_ready; mem_addr holds the originally latched value.
